// File: rtl/seq_magnitude_compare.sv
// Multi-cycle magnitude comparator. It walks the operands MSB-first, one slice
// per clock, and stops at the first slice that differs. Signed mode offsets the
// top slice so a plain unsigned compare gives the two's complement order.
// The 74LS85-style cascade input resolves equal operands, so several
// instances can be chained to compare wider words.
module seq_magnitude_compare #(
    parameter int DATA_WIDTH  = 16,
    parameter int SLICE_WIDTH = 4
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iStart,
    input  logic                  iSigned,
    input  logic [DATA_WIDTH-1:0] iData_a,
    input  logic [DATA_WIDTH-1:0] iData_b,
    input  logic [2:0]            iData,
    output logic [2:0]            oData,
    output logic                  oBusy,
    output logic                  oDone
);

    // DATA_WIDTH is expected to be a positive multiple of SLICE_WIDTH.
    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } stateType;

    stateType              stateReg;
    logic [DATA_WIDTH-1:0] aReg;
    logic [DATA_WIDTH-1:0] bReg;
    logic [2:0]            cascadeReg;
    logic                  signedReg;
    logic [IDX_W-1:0]      idxReg;
    logic [2:0]            dataReg;
    logic                  busyReg;
    logic                  doneReg;

    logic [SLICE_WIDTH-1:0] aSlices [NUM_SLICES];
    logic [SLICE_WIDTH-1:0] bSlices [NUM_SLICES];
    logic [SLICE_WIDTH-1:0] aSel;
    logic [SLICE_WIDTH-1:0] bSel;
    logic [2:0]             cascadeResult;

    // Split the latched operands into slices, slice 0 holding the LSBs.
    generate
        for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : gSlice
            assign aSlices[gi] = aReg[gi*SLICE_WIDTH +: SLICE_WIDTH];
            assign bSlices[gi] = bReg[gi*SLICE_WIDTH +: SLICE_WIDTH];
        end
    endgenerate

    // Select the current slice and, in signed mode, flip the sign bit of the top slice.
    always_comb begin
        aSel = aSlices[idxReg];
        bSel = bSlices[idxReg];
        if (signedReg && (idxReg == TOP_IDX)) begin
            aSel[SLICE_WIDTH-1] = ~aSel[SLICE_WIDTH-1];
            bSel[SLICE_WIDTH-1] = ~bSel[SLICE_WIDTH-1];
        end
    end

    // 74LS85 cascade resolution for fully equal operands.
    always_comb begin
        cascadeResult = 3'b001;
        if (cascadeReg[0]) begin
            cascadeResult = 3'b001;
        end else begin
            case (cascadeReg[2:1])
                2'b10:   cascadeResult = 3'b100;
                2'b01:   cascadeResult = 3'b010;
                2'b11:   cascadeResult = 3'b000;
                default: cascadeResult = 3'b110;
            endcase
        end
    end

    // Control FSM with the latched operands and registered outputs.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            stateReg   <= IDLE;
            aReg       <= '0;
            bReg       <= '0;
            cascadeReg <= '0;
            signedReg  <= 1'b0;
            idxReg     <= '0;
            dataReg    <= 3'b000;
            busyReg    <= 1'b0;
            doneReg    <= 1'b0;
        end else begin
            doneReg <= 1'b0;
            case (stateReg)
                IDLE, DONE: begin
                    if (iStart) begin
                        aReg       <= iData_a;
                        bReg       <= iData_b;
                        cascadeReg <= iData;
                        signedReg  <= iSigned;
                        idxReg     <= TOP_IDX;
                        busyReg    <= 1'b1;
                        stateReg   <= COMPARE;
                    end else begin
                        busyReg  <= 1'b0;
                        stateReg <= IDLE;
                    end
                end
                COMPARE: begin
                    if (aSel > bSel) begin
                        dataReg  <= 3'b100;
                        busyReg  <= 1'b0;
                        doneReg  <= 1'b1;
                        stateReg <= DONE;
                    end else if (aSel < bSel) begin
                        dataReg  <= 3'b010;
                        busyReg  <= 1'b0;
                        doneReg  <= 1'b1;
                        stateReg <= DONE;
                    end else if (idxReg != '0) begin
                        idxReg <= idxReg - 1'b1;
                    end else begin
                        dataReg  <= cascadeResult;
                        busyReg  <= 1'b0;
                        doneReg  <= 1'b1;
                        stateReg <= DONE;
                    end
                end
                default: begin
                    busyReg  <= 1'b0;
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    assign oData = dataReg;
    assign oBusy = busyReg;
    assign oDone = doneReg;

endmodule

// File: tb/tb_seq_magnitude_compare.sv
// Directed bench for seq_magnitude_compare (16-bit operands, 4-bit slices).
module tb_seq_magnitude_compare;

    logic        iClk = 1'b0;
    logic        iReset = 1'b0;
    logic        iStart = 1'b0;
    logic        iSigned = 1'b0;
    logic [15:0] iData_a = '0;
    logic [15:0] iData_b = '0;
    logic [2:0]  iData = '0;
    logic [2:0]  oData;
    logic        oBusy;
    logic        oDone;

    int checks = 0;
    int errors = 0;

    seq_magnitude_compare #(.DATA_WIDTH(16), .SLICE_WIDTH(4)) dut (
        .iClk    (iClk),
        .iReset  (iReset),
        .iStart  (iStart),
        .iSigned (iSigned),
        .iData_a (iData_a),
        .iData_b (iData_b),
        .iData   (iData),
        .oData   (oData),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    always #5 iClk = ~iClk;

    // Drive one start request; returns 1 ns after the edge that samples it.
    task automatic startOp(input logic [15:0] a, input logic [15:0] b,
                           input logic s, input logic [2:0] casc);
        @(negedge iClk);
        iData_a = a;
        iData_b = b;
        iSigned = s;
        iData   = casc;
        iStart  = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
    endtask

    // Count edges until oDone (bounded); also count cycles with oBusy high.
    task automatic waitDone(output int cycles, output int busyCycles, output bit timedOut);
        cycles     = 0;
        busyCycles = 0;
        timedOut   = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (oBusy) busyCycles++;
            @(posedge iClk);
            #1;
            cycles++;
            if (oDone) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        iReset = 1'b1;
        repeat (2) @(posedge iClk);
        #1;
        iReset = 1'b0;
        checks++;
        if ({oData, oBusy, oDone} !== 5'b000_0_0) begin
            errors++;
            $display("FAIL reset_state: got data=%b busy=%b done=%b want 000/0/0", oData, oBusy, oDone);
        end
        $display("reset: data=%b busy=%b done=%b", oData, oBusy, oDone);
    endtask

    task automatic test_unsigned_max;
        int cyc, bcyc;
        bit to;
        startOp(16'hFFFF, 16'h0000, 1'b0, 3'b000);
        waitDone(cyc, bcyc, to);
        checks++;
        if (to || cyc != 1 || oData !== 3'b100) begin
            errors++;
            $display("FAIL ffff_vs_0: got data=%b cycles=%0d timeout=%0b want 100 after 1", oData, cyc, to);
        end
        checks++;
        if (bcyc != 1) begin
            errors++;
            $display("FAIL ffff_vs_0_busy: got busy cycles=%0d want 1", bcyc);
        end
        @(posedge iClk);
        #1;
        checks++;
        if (oDone !== 1'b0 || oData !== 3'b100) begin
            errors++;
            $display("FAIL done_pulse_width: got done=%b data=%b want 0 and held 100", oDone, oData);
        end
        $display("op A=ffff B=0000 u: data=%b cycles=%0d", oData, cyc);
    endtask

    task automatic test_signed_mode;
        int cyc, bcyc;
        bit to;
        startOp(16'h0000, 16'hFFFF, 1'b0, 3'b000);
        waitDone(cyc, bcyc, to);
        checks++;
        if (to || cyc != 1 || oData !== 3'b010) begin
            errors++;
            $display("FAIL 0_vs_ffff_unsigned: got data=%b cycles=%0d want 010 after 1", oData, cyc);
        end
        $display("op A=0000 B=ffff u: data=%b cycles=%0d", oData, cyc);
        startOp(16'h0000, 16'hFFFF, 1'b1, 3'b000);
        waitDone(cyc, bcyc, to);
        checks++;
        if (to || cyc != 1 || oData !== 3'b100) begin
            errors++;
            $display("FAIL 0_vs_ffff_signed: got data=%b cycles=%0d want 100 after 1", oData, cyc);
        end
        $display("op A=0000 B=ffff s: data=%b cycles=%0d", oData, cyc);
    endtask

    task automatic test_cascade;
        logic [2:0] cascIn  [5] = '{3'b100, 3'b010, 3'b001, 3'b000, 3'b110};
        logic [2:0] cascOut [5] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b000};
        int cyc, bcyc;
        bit to;
        for (int i = 0; i < 5; i++) begin
            startOp(16'hC00C, 16'hC00C, 1'b0, cascIn[i]);
            waitDone(cyc, bcyc, to);
            checks++;
            if (to || cyc != 4 || oData !== cascOut[i]) begin
                errors++;
                $display("FAIL cascade_%b: got data=%b cycles=%0d want %b after 4",
                         cascIn[i], oData, cyc, cascOut[i]);
            end
            $display("op A=B=c00c casc=%b: data=%b cycles=%0d", cascIn[i], oData, cyc);
        end
    endtask

    task automatic test_ignore_busy_start;
        int cyc, bcyc, extraDone;
        bit to;
        startOp(16'h1234, 16'h1235, 1'b0, 3'b001);
        iData_a = 16'h0000;
        iData_b = 16'h0000;
        iStart  = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        waitDone(cyc, bcyc, to);
        checks++;
        if (to || cyc + 1 != 4 || oData !== 3'b010) begin
            errors++;
            $display("FAIL busy_start_ignored: got data=%b cycles=%0d want 010 after 4", oData, cyc + 1);
        end
        extraDone = 0;
        repeat (6) begin
            @(posedge iClk);
            #1;
            if (oDone) extraDone++;
        end
        checks++;
        if (extraDone != 0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL no_second_result: got extra done=%0d busy=%b want 0/0", extraDone, oBusy);
        end
        $display("op A=1234 B=1235 u: data=%b cycles=%0d", oData, cyc + 1);
    endtask

    task automatic test_back_to_back;
        int cyc, bcyc;
        bit to;
        startOp(16'h8000, 16'h7FFF, 1'b1, 3'b000);
        waitDone(cyc, bcyc, to);
        checks++;
        if (to || cyc != 1 || oData !== 3'b010) begin
            errors++;
            $display("FAIL signed_min_vs_max: got data=%b cycles=%0d want 010 after 1", oData, cyc);
        end
        $display("op A=8000 B=7fff s: data=%b cycles=%0d", oData, cyc);
        // Now in the DONE cycle: request the next comparison immediately.
        iData_a = 16'h0005;
        iData_b = 16'h0003;
        iStart  = 1'b1;
        @(posedge iClk);
        #1;
        iStart = 1'b0;
        checks++;
        if (oBusy !== 1'b1 || oData !== 3'b010) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b data=%b want 1 and held 010", oBusy, oData);
        end
        waitDone(cyc, bcyc, to);
        checks++;
        if (to || cyc != 4 || oData !== 3'b100) begin
            errors++;
            $display("FAIL b2b_result: got data=%b cycles=%0d want 100 after 4", oData, cyc);
        end
        $display("op A=0005 B=0003 s: data=%b cycles=%0d", oData, cyc);
    endtask

    task automatic test_reset_abort;
        int cyc, bcyc, extraDone;
        bit to;
        startOp(16'hAAAA, 16'hAAAA, 1'b0, 3'b100);
        @(posedge iClk);
        #1;
        iReset = 1'b1;
        @(posedge iClk);
        #1;
        iReset = 1'b0;
        checks++;
        if ({oData, oBusy, oDone} !== 5'b000_0_0) begin
            errors++;
            $display("FAIL reset_abort: got data=%b busy=%b done=%b want 000/0/0", oData, oBusy, oDone);
        end
        extraDone = 0;
        repeat (6) begin
            @(posedge iClk);
            #1;
            if (oDone) extraDone++;
        end
        checks++;
        if (extraDone != 0) begin
            errors++;
            $display("FAIL reset_no_done: got done pulses=%0d want 0", extraDone);
        end
        $display("op A=B=aaaa aborted: data=%b busy=%b", oData, oBusy);
        startOp(16'h0005, 16'h0003, 1'b0, 3'b000);
        waitDone(cyc, bcyc, to);
        checks++;
        if (to || cyc != 4 || oData !== 3'b100) begin
            errors++;
            $display("FAIL after_reset: got data=%b cycles=%0d want 100 after 4", oData, cyc);
        end
        $display("op A=0005 B=0003 u: data=%b cycles=%0d", oData, cyc);
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed_mode();
        test_cascade();
        test_ignore_busy_start();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
